// File: rtl/vc_test_delay_sink.sv
// Val/rdy test sink: throttles in_rdy by delay_amt cycles per transfer and checks
// received messages against a preloaded table. Optional macro: VC_TEST_SINK_STOP_ON_ERROR_EN.
module vc_test_delay_sink #(
   parameter int p_msg_nbits = 1,
   parameter int p_num_msgs  = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   delay_amt,
   input  logic                          ld_en,
   input  logic [$clog2(p_num_msgs)-1:0] ld_idx,
   input  logic [p_msg_nbits-1:0]        ld_msg,
   input  logic [$clog2(p_num_msgs):0]   num_msgs,
   input  logic                          in_val,
   output logic                          in_rdy,
   input  logic [p_msg_nbits-1:0]        in_msg,
   output logic                          done,
   output logic [$clog2(p_num_msgs):0]   num_rcvd,
   output logic [31:0]                   num_errors,
   output logic                          err
);

   localparam int c_aw = $clog2(p_num_msgs);
   localparam logic [c_aw:0] c_one = (c_aw+1)'(1);

   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_DONE = 2'd1;
`ifdef VC_TEST_SINK_STOP_ON_ERROR_EN
   localparam logic [1:0] ST_ERR  = 2'd2;
`endif

   logic [1:0]             state;
   logic [31:0]            cnt;
   logic                   reload;
   logic [c_aw:0]          idx;
   logic [p_msg_nbits-1:0] table_mem [p_num_msgs];

   logic [31:0]            eff_cnt;
   logic                   xfer;
   logic                   mismatch;

   always_ff @(posedge clk) begin
      if (ld_en)
         table_mem[ld_idx] <= ld_msg;
   end

   // A pending reload makes delay_amt visible in the same cycle, so zero delay
   // gives back-to-back transfers with no dead cycle.
   always_comb begin
      eff_cnt  = reload ? delay_amt : cnt;
      in_rdy   = reset && (state == ST_WAIT) && (eff_cnt == '0) && (num_msgs != '0);
      xfer     = in_val && in_rdy;
      mismatch = (in_msg != table_mem[idx[c_aw-1:0]]);
      num_rcvd = idx;
`ifdef VC_TEST_SINK_STOP_ON_ERROR_EN
      done     = (state == ST_DONE) || (state == ST_ERR);
      err      = (xfer && mismatch) || (state == ST_ERR);
`else
      done     = (state == ST_DONE);
      err      = xfer && mismatch;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_WAIT;
         cnt        <= '0;
         reload     <= 1'b1;
         idx        <= '0;
         num_errors <= '0;
      end else if (state == ST_WAIT) begin
         if (num_msgs == '0) begin
            state <= ST_DONE;
         end else if (xfer) begin
            idx    <= idx + c_one;
            reload <= 1'b1;
            if (mismatch && (num_errors != '1))
               num_errors <= num_errors + 32'd1;
`ifdef VC_TEST_SINK_STOP_ON_ERROR_EN
            if (mismatch)
               state <= ST_ERR;
            else if ((idx + c_one) == num_msgs)
               state <= ST_DONE;
`else
            if ((idx + c_one) == num_msgs)
               state <= ST_DONE;
`endif
         end else if (eff_cnt != '0) begin
            cnt    <= eff_cnt - 32'd1;
            reload <= 1'b0;
         end else begin
            cnt    <= '0;
            reload <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
      !$isunknown({delay_amt, in_val, num_msgs}));
   a_msg_known: assert property (@(posedge clk) disable iff (!reset)
      (in_val && in_rdy) |-> !$isunknown(in_msg));
`endif

endmodule

// File: tb/tb_vc_test_delay_sink.sv
// Randomized bench for vc_test_delay_sink: a cycle-level model built from
// "cycles since reload >= delay" arithmetic, plus directed literal checks.
module tb_vc_test_delay_sink;

   localparam int MW = 8;
   localparam int NM = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   delay_amt;
   logic          ld_en;
   logic [AW-1:0] ld_idx;
   logic [MW-1:0] ld_msg;
   logic [AW:0]   num_msgs;
   logic          in_val;
   logic          in_rdy;
   logic [MW-1:0] in_msg;
   logic          done;
   logic [AW:0]   num_rcvd;
   logic [31:0]   num_errors;
   logic          err;

   always #5 clk = ~clk;

   vc_test_delay_sink #(.p_msg_nbits(MW), .p_num_msgs(NM)) dut (
      .clk(clk), .reset(reset), .delay_amt(delay_amt), .ld_en(ld_en),
      .ld_idx(ld_idx), .ld_msg(ld_msg), .num_msgs(num_msgs), .in_val(in_val),
      .in_rdy(in_rdy), .in_msg(in_msg), .done(done), .num_rcvd(num_rcvd),
      .num_errors(num_errors), .err(err)
   );

`ifdef VC_TEST_SINK_STOP_ON_ERROR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   int n_total = 0;
   int n_bad   = 0;

   logic [MW-1:0] tab [NM];
   logic [MW-1:0] src [NM];
   int     m_since, m_rcvd, m_st, cyc, rdy_hi, err_seen;
   longint m_errs;
   int     xfer_at [$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare outputs at negedge against the model, advance model, then
   // return at posedge+1 so the caller can drive the next cycle's inputs.
   task automatic step();
      bit e_rdy, xf, mis;
      @(negedge clk);
      if (!reset) begin
         chk("rst_rdy", in_rdy, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_rcvd", num_rcvd, 0);
         chk("rst_errs", num_errors, 0);
         m_since = 0; m_rcvd = 0; m_errs = 0; m_st = 0; cyc = 0;
      end else begin
         e_rdy = (m_st == 0) && (num_msgs != 0) && (longint'(m_since) >= longint'(delay_amt));
         xf    = in_val && e_rdy;
         mis   = xf && (in_msg != tab[m_rcvd % NM]);
         chk("rdy", in_rdy, e_rdy);
         chk("done", done, m_st != 0);
         chk("err", err, mis || (m_st == 2));
         chk("rcvd", num_rcvd, m_rcvd);
         chk("errs", num_errors, m_errs);
         if (e_rdy) rdy_hi++;
         if (mis) err_seen++;
         if (m_st == 0) begin
            if (num_msgs == 0) m_st = 1;
            else if (xf) begin
               xfer_at.push_back(cyc);
               m_rcvd++;
               m_since = 0;
               if (mis && m_errs != 64'hFFFF_FFFF) m_errs++;
               if (STOP && mis) m_st = 2;
               else if (m_rcvd == int'(num_msgs)) m_st = 1;
            end else m_since++;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   // Assert reset, load n table entries while in reset, then release.
   task automatic start_test(input int nm, input int d, input bit rnd);
      reset = 1'b0;
      in_val = 1'b0;
      num_msgs = (AW+1)'(nm);
      delay_amt = d;
      for (int i = 0; i < nm; i++) begin
         if (rnd) src[i] = MW'($urandom);
         ld_en = 1'b1; ld_idx = AW'(i); ld_msg = src[i];
         step();
         tab[i] = src[i];
      end
      ld_en = 1'b0;
      step();
      reset = 1'b1;
      xfer_at.delete();
      rdy_hi = 0;
      err_seen = 0;
   endtask

   task automatic run(input int budget, input int pval, input int perr, input int max_x);
      for (int i = 0; i < budget; i++) begin
         in_val = ($urandom_range(99) < pval);
         if ($urandom_range(99) < perr) in_msg = MW'($urandom);
         else in_msg = src[m_rcvd % NM];
         step();
         if (m_st != 0 || m_rcvd >= max_x) break;
      end
   endtask

   task automatic finish_check(input string name);
      chk(name, done, 1);
      in_val = 1'b1;
      step();
      step();
   endtask

   initial begin
      reset = 1'b0; delay_amt = '0; ld_en = 1'b0; ld_idx = '0; ld_msg = '0;
      num_msgs = '0; in_val = 1'b0; in_msg = '0;
      @(posedge clk); #1;

      // back-to-back, zero delay
      src[0] = 8'h1; src[1] = 8'h2; src[2] = 8'h3; src[3] = 8'h4;
      start_test(4, 0, 0);
      run(50, 100, 0, 99);
      chk("t1_nxfer", xfer_at.size(), 4);
      for (int i = 0; i < xfer_at.size() && i < 4; i++) chk("t1_xfer_cycle", xfer_at[i], i);
      chk("t1_rcvd", num_rcvd, 4);
      chk("t1_errs", num_errors, 0);
      finish_check("t1_done");

      // delay 3, in_val held high
      src[0] = 8'h55; src[1] = 8'hAA;
      start_test(2, 3, 0);
      run(50, 100, 0, 99);
      chk("t2_nxfer", xfer_at.size(), 2);
      if (xfer_at.size() == 2) begin
         chk("t2_xfer0", xfer_at[0], 3);
         chk("t2_xfer1", xfer_at[1], 7);
      end
      chk("t2_rdy_hi", rdy_hi, 2);
      chk("t2_rcvd", num_rcvd, 2);
      finish_check("t2_done");

      // one bad message in the middle
      src[0] = 8'hA; src[1] = 8'hB; src[2] = 8'hC;
      start_test(3, 0, 0);
      src[1] = 8'hF;
      run(50, 100, 0, 99);
      chk("t3_err_pulses", err_seen, 1);
      chk("t3_errs", num_errors, 1);
      if (STOP) begin
         chk("t3_rcvd", num_rcvd, 2);
         chk("t3_err_level", err, 1);
      end else begin
         chk("t3_rcvd", num_rcvd, 3);
      end
      finish_check("t3_done");
      chk("t3_rdy_after", in_rdy, 0);

      // delay 2, in_val idle for 10 cycles
      src[0] = 8'h33;
      start_test(1, 2, 0);
      run(10, 0, 0, 99);
      chk("t4_rdy_hi", rdy_hi, 8);
      chk("t4_rdy_now", in_rdy, 1);
      run(20, 100, 0, 99);
      chk("t4_nxfer", xfer_at.size(), 1);
      if (xfer_at.size() == 1) chk("t4_xfer0", xfer_at[0], 10);
      finish_check("t4_done");

      // reset mid-test after 3 transfers, then a full fresh run
      start_test(8, 1, 1);
      run(100, 100, 0, 3);
      chk("t5_partial", num_rcvd, 3);
      reset = 1'b0;
      #1;
      chk("t5_rst_rcvd", num_rcvd, 0);
      start_test(8, 1, 1);
      run(100, 100, 0, 99);
      chk("t5_nxfer", xfer_at.size(), 8);
      chk("t5_rcvd", num_rcvd, 8);
      finish_check("t5_done");

      // num_msgs == 0
      start_test(0, 0, 0);
      in_val = 1'b1;
      step();
      chk("t6_done", done, 1);
      step();
      step();
      chk("t6_rdy_hi", rdy_hi, 0);

      // randomized tests
      for (int t = 0; t < 24; t++) begin
         start_test(int'($urandom_range(NM, 1)), int'($urandom_range(4, 0)), 1);
         run(400, int'($urandom_range(100, 30)), 15, 99);
         finish_check("rnd_done");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/vc_test_delay_sink.md
Name: vc_test_delay_sink

Overview:
- Test-harness consumer for the val/rdy message interface.
- It is the receiving end that pairs with our source-side fixed-delay throttle.
- Holds off `in_rdy` for a programmable number of cycles before each transfer, which applies back-pressure.
- Compares each received message against a preloaded expected-message table, and reports `done` and error counts to the harness.

Parameters:
p_msg_nbits, 1, width of message in bits
p_num_msgs, 1024, depth of expected-message table (max messages per test)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
delay_amt  input  32  cycles of rdy hold-off before each transfer; sampled at each counter reload
ld_en  input  1  write enable for expected-message table
ld_idx  input  $clog2(p_num_msgs)  table write index
ld_msg  input  p_msg_nbits  expected message to write
num_msgs  input  $clog2(p_num_msgs)+1  number of messages expected in this test
in_val  input  1  upstream message valid
in_rdy  output  1  sink ready
in_msg  input  p_msg_nbits  upstream message
done  output  1  all num_msgs messages received
num_rcvd  output  $clog2(p_num_msgs)+1  messages accepted so far
num_errors  output  32  mismatches detected so far
err  output  1  one-cycle pulse on the cycle a mismatching message is accepted

Behaviour:
- Reset (reset==0, async): state=WAIT, delay counter=0, index=0, num_errors=0. Outputs: in_rdy=0, done=0, err=0, num_rcvd=0.
  - The table contents are not reset; the harness loads the table while reset is asserted or before the first transfer.
- Table: synchronous write on posedge when ld_en=1. Table reads are combinational at the current index.
- Delay counter reload:
  - On the first cycle after reset deassertion, the counter loads delay_amt.
  - It reloads delay_amt again on the cycle after every accepted transfer.
- States:
  - WAIT:
    - If counter>0, decrement the counter and hold in_rdy=0.
    - If counter==0, in_rdy=1.
    - A transfer occurs when in_val && in_rdy.
    - On transfer: compare in_msg against table[index]. On mismatch, num_errors+=1 and err=1 for that cycle. Then index+=1, and reload the counter next cycle.
    - If index+1==num_msgs on a transfer, go to DONE next cycle.
  - DONE: in_rdy=0, done=1. Remain in DONE until reset.
- in_val with counter>0: no transfer, no error. The sink does not require upstream to hold the message; the protocol does.
- Zero delay (delay_amt==0): in_rdy=1 in every WAIT cycle, so one message is accepted per cycle back-to-back.
- Delay N>0: exactly N cycles of in_rdy=0 precede each in_rdy=1 window. The count starts from reset release or the previous transfer, independent of in_val.
- num_msgs==0: go from WAIT to DONE on the first cycle after reset release; in_rdy never rises.
- num_errors saturates at 32'hFFFFFFFF.
- num_rcvd equals the index register.
- Reset mid-test: all state returns to the reset values immediately. Partial counts are lost.
- X checks (when not in reset):
  - delay_amt, in_val and num_msgs are asserted not-X at posedge.
  - in_msg is asserted not-X on any transfer.

Optional Feature:
- Macro: VC_TEST_SINK_STOP_ON_ERROR_EN.
- Defined: the first mismatch moves the FSM to a third state, ERR, on the next cycle.
  - ERR holds in_rdy=0, done=1, err=1 (level, not pulse) until reset.
  - num_rcvd includes the failing message.
- Undefined: mismatches only pulse err and increment num_errors; reception continues to num_msgs.

Test Plan:
- delay_amt=0, num_msgs=4, table {0x1,0x2,0x3,0x4}, source always valid with matching data.
  -> 4 transfers on 4 consecutive cycles; done=1 the cycle after the 4th; num_errors=0.
- delay_amt=3, num_msgs=2, matching data, in_val held high.
  -> in_rdy low 3 cycles, high 1, low 3, high 1; done after the 2nd transfer; num_rcvd=2.
- delay_amt=0, num_msgs=3, table {0xA,0xB,0xC}, sent {0xA,0xF,0xC}.
  -> err pulses on the 2nd transfer only; num_errors=1; done=1.
  -> With VC_TEST_SINK_STOP_ON_ERROR_EN: enters ERR; in_rdy stays 0; num_rcvd=2; 3rd message never accepted.
- delay_amt=2, in_val low for 10 cycles, then high.
  -> in_rdy rises 2 cycles after reset release and stays high; transfer on the first in_val cycle.
- num_msgs=8, delay_amt=1; reset asserted (0) after 3 transfers, table reloaded, reset released.
  -> Counters read 0 during reset; test completes from index 0 with 8 fresh transfers.
- num_msgs=0.
  -> done=1 on the first cycle after reset release; in_rdy never 1.
